// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic pipeline stage.
//   pipe_occ_e : stage occupancy state, also driven out as the 2-bit
//                occupancy count (EMPTY=0, ONE=1, TWO=2).
package pipe_stage_elastic_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } pipe_occ_e;

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter, reusable for perf CSRs.
//   clk, reset : clock, synchronous active-high reset
//   inc        : count one this cycle (ignored once at all-ones)
//   clr        : synchronous clear
//   value      : current count
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      value_q <= '0;
    end else if (inc && (value_q != '1)) begin
      value_q <= value_q + CNT_W'(1);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with flush, optional 2-entry skid
// buffer and a saturating stall-cycle counter.
//   clk, reset           : clock, synchronous active-high reset
//   flush                : drop all held entries
//   in_valid/in_ready    : upstream handshake, in_data payload
//   out_valid/out_ready  : downstream handshake, out_data payload
//   out_bubble           : !out_valid
//   occupancy            : entries held (0..2)
//   stall_cnt            : cycles with out_valid && !out_ready, saturating
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int unsigned      WIDTH         = 64,
  parameter logic [WIDTH-1:0] RESET_PAYLOAD = '0,
  parameter bit               SKID          = 1'b1,
  parameter int unsigned      CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_bubble,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_occ_e        state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             push, pop;

  assign out_valid  = (state_q != OCC_EMPTY);
  assign out_bubble = !out_valid;
  assign out_data   = main_q;
  assign occupancy  = state_q;

  // Skid mode breaks the ready path with a register; the single-entry
  // variant passes downstream ready straight through.
  assign in_ready = SKID ? in_ready_q : (!out_valid || out_ready);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      OCC_EMPTY: begin
        if (push) begin
          state_d = OCC_ONE;
          main_d  = in_data;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          // Only reachable with SKID: in single-register mode a push while
          // full implies out_ready, hence a pop.
          state_d = OCC_TWO;
          skid_d  = in_data;
        end else if (pop) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          state_d = OCC_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    // Flush wins; main keeps its old value so out_data does not change.
    if (flush) begin
      state_d = OCC_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= OCC_EMPTY;
      main_q     <= RESET_PAYLOAD;
      skid_q     <= RESET_PAYLOAD;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != OCC_TWO);
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid && !out_ready),
    .clr   (1'b0),
    .value (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench: dut1 is the skid variant (CNT_W=4), dut0 the
// single-register variant (CNT_W=8). Both share upstream/downstream stimulus.
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_data;

  logic        in_ready1, out_valid1, out_bubble1;
  logic [31:0] out_data1;
  logic [1:0]  occ1;
  logic [3:0]  stall1;

  logic        in_ready0, out_valid0, out_bubble0;
  logic [31:0] out_data0;
  logic [1:0]  occ0;
  logic [7:0]  stall0;

  localparam logic [31:0] RST1 = 32'hDEAD_BEEF;
  localparam logic [31:0] RST0 = 32'h5A5A_5A5A;

  int checks = 0;
  int failures = 0;
  logic [31:0] q1[$];
  logic [31:0] q0[$];
  int s1 = 0, s0 = 0;
  int pops1 = 0, pops0 = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(
    .WIDTH(32), .RESET_PAYLOAD(RST1), .SKID(1'b1), .CNT_W(4)
  ) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_bubble(out_bubble1), .occupancy(occ1), .stall_cnt(stall1)
  );

  pipe_stage_elastic #(
    .WIDTH(32), .RESET_PAYLOAD(RST0), .SKID(1'b0), .CNT_W(8)
  ) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_bubble(out_bubble0), .occupancy(occ0), .stall_cnt(stall0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the skid variant; handshakes decided at this negedge
  // take effect at the following posedge.
  always @(negedge clk) begin
    if (reset) begin
      q1.delete();
      s1 = 0;
    end else begin
      check("occ1", 64'(occ1), 64'(q1.size()));
      check("valid1", 64'(out_valid1), 64'(q1.size() != 0));
      check("bubble1", 64'(out_bubble1), 64'(q1.size() == 0));
      check("rdy1", 64'(in_ready1), 64'(q1.size() != 2));
      check("stall1", 64'(stall1), 64'(s1));
      if (q1.size() != 0 && !out_ready && s1 < 15) s1++;
      if (q1.size() != 0 && out_ready) begin
        check("data1", 64'(out_data1), 64'(q1[0]));
        void'(q1.pop_front());
        pops1++;
      end
      if (flush) q1.delete();
      else if (in_valid && q1.size() != 2) q1.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      q0.delete();
      s0 = 0;
    end else begin
      check("occ0", 64'(occ0), 64'(q0.size()));
      check("valid0", 64'(out_valid0), 64'(q0.size() != 0));
      check("rdy0", 64'(in_ready0), 64'(q0.size() == 0 || out_ready));
      check("stall0", 64'(stall0), 64'(s0));
      if (q0.size() != 0 && !out_ready && s0 < 255) s0++;
      if (q0.size() != 0 && out_ready) begin
        check("data0", 64'(out_data0), 64'(q0[0]));
        void'(q0.pop_front());
        pops0++;
      end
      if (flush) q0.delete();
      else if (in_valid && (q0.size() == 0 || out_ready)) q0.push_back(in_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gaps1, gaps0, p1s, p0s;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    check("rst_valid", 64'(out_valid1), 64'd0);
    check("rst_bubble", 64'(out_bubble1), 64'd1);
    check("rst_data1", 64'(out_data1), 64'(RST1));
    check("rst_data0", 64'(out_data0), 64'(RST0));
    check("rst_rdy", 64'(in_ready1), 64'd1);

    // first transfer latency
    in_valid = 1'b1; in_data = 32'h8000_0000; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("t1_valid", 64'(out_valid1), 64'd1);
    check("t1_data", 64'(out_data1), 64'h8000_0000);
    check("t1_bubble", 64'(out_bubble1), 64'd0);
    check("t1_occ", 64'(occ1), 64'd1);
    check("t1_data0", 64'(out_data0), 64'h8000_0000);
    cyc();

    // skid fill, stall counting, ordered drain
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    cyc();
    in_data = 32'hB;
    cyc();
    in_valid = 1'b0;
    check("t2_occ", 64'(occ1), 64'd2);
    check("t2_rdy", 64'(in_ready1), 64'd0);
    repeat (3) cyc();
    check("t2_stall", 64'(stall1), 64'd4);
    check("t2_head", 64'(out_data1), 64'hA);
    out_ready = 1'b1;
    cyc();
    check("t2_second", 64'(out_data1), 64'hB);
    cyc();
    check("t2_drained", 64'(occ1), 64'd0);

    // full-throughput stream
    reset = 1'b1; cyc(); reset = 1'b0;
    out_ready = 1'b1; gaps1 = 0; gaps0 = 0; p1s = pops1; p0s = pops0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      cyc();
      if (!out_valid1) gaps1++;
      if (!out_valid0) gaps0++;
    end
    in_valid = 1'b0;
    cyc(); cyc();
    check("t3_gaps1", 64'(gaps1), 64'd0);
    check("t3_gaps0", 64'(gaps0), 64'd0);
    check("t3_pops1", 64'(pops1 - p1s), 64'd16);
    check("t3_pops0", 64'(pops0 - p0s), 64'd16);
    check("t3_stall1", 64'(stall1), 64'd0);
    check("t3_stall0", 64'(stall0), 64'd0);

    // flush with coincident push
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    cyc();
    in_data = 32'h22;
    cyc();
    check("t4_occ", 64'(occ1), 64'd2);
    flush = 1'b1; in_data = 32'h33;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("t4_valid", 64'(out_valid1), 64'd0);
    check("t4_occ0", 64'(occ1), 64'd0);
    check("t4_rdy", 64'(in_ready1), 64'd1);
    check("t4_data", 64'(out_data1), 64'h11);
    out_ready = 1'b1;
    repeat (3) cyc();
    check("t4_nothing", 64'(out_valid1), 64'd0);

    // stall counter saturation
    reset = 1'b1; cyc(); reset = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
    cyc();
    in_valid = 1'b0;
    repeat (20) cyc();
    check("t5_sat1", 64'(stall1), 64'd15);
    check("t5_cnt0", 64'(stall0), 64'd20);

    // reset while full
    in_valid = 1'b1; in_data = 32'h66;
    cyc();
    in_valid = 1'b0;
    check("t6_occ", 64'(occ1), 64'd2);
    reset = 1'b1;
    cyc();
    check("t6_valid", 64'(out_valid1), 64'd0);
    check("t6_data", 64'(out_data1), 64'(RST1));
    check("t6_stall", 64'(stall1), 64'd0);
    check("t6_rdy", 64'(in_ready1), 64'd1);
    reset = 1'b0;
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
